ro_buffer_param: RTL and testbench
==================================

// Module: ro_buffer_param
// PURPOSE
//  Parametrised reorder buffer; successor of the fixed-size ROB. Allocates in-order tags to the issuer,
//  collects results from the LSB and RS writeback buses, and retires one entry per cycle in program
//  order to the reg file. Adds an exact full flag, a store-commit pulse to the LSB, and a self-clearing
//  mispredict flush.
// PARAMETERS
//  DEPTH      16  entries; power of two, >=4; tags are 1..DEPTH, tag 0 = "none"
//  ID_W       5   tag width, = log2(DEPTH)+1
//  XLEN       32  data / pc width
//  RID_W      5   architectural register id width
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous, active-high reset
//  rdy            in   1      global enable; 0 freezes all state
//  alloc_valid    in   1      issuer requests an entry this cycle
//  alloc_kind     in   2      0 NORMAL, 1 BRANCH, 2 STORE, 3 LOAD
//  alloc_rd       in   RID_W  destination reg (0 = none)
//  alloc_pc       in   XLEN   instruction pc
//  alloc_pred_npc in   XLEN   predicted next pc (BRANCH only)
//  alloc_ready    out  1      comb: !full && !flush
//  alloc_id       out  ID_W   comb: tag given to this cycle's allocation (= tail)
//  full / empty   out  1      comb: count==DEPTH / count==0
//  q1, q2         in   ID_W   operand tags to look up
//  q1_ok, q2_ok   out  1      comb: operand value available
//  v1, v2         out  XLEN   comb: operand value
//  wb0_id, wb0_val in  ID_W,XLEN  LSB writeback (id 0 = idle)
//  wb1_id, wb1_val, wb1_npc in ID_W,XLEN,XLEN  RS writeback; npc = resolved next pc
//  commit_valid   out  1      reg pulse: entry retired to reg file
//  commit_id      out  ID_W   reg: retired tag
//  commit_rd      out  RID_W  reg: destination reg
//  commit_value   out  XLEN   reg: result
//  st_commit_valid out 1      reg pulse: head STORE may write memory
//  st_commit_id   out  ID_W   reg: tag of that store
//  br_valid, br_taken out 1   reg pulse: branch retired / actual taken
//  br_pc          out  XLEN   reg: pc of retired branch
//  flush          out  1      reg pulse: mispredict; all younger work squashed
//  flush_pc       out  XLEN   reg: correct next pc
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): head=tail=1, count=0, all entry busy/done=0; every registered output 0.
//  - rdy=0: no state change; all pulse outputs (commit_valid, st_commit_valid, br_valid, flush) go 0.
//  - Alloc: alloc_valid && alloc_ready -> entry[tail] busy=1, done=0, fields latched; tail wraps DEPTH->1.
//    alloc_valid while !alloc_ready is ignored (no state change). No bypass: full with same-cycle commit
//    still refuses.
//  - Writeback: wbN_id!=0 and entry busy -> done=1, value latched (wb1 also latches actual npc).
//    Writeback to non-busy tag ignored. wb0 and wb1 never carry the same tag.
//  - Lookup: q==0 -> ok=0, v=0; else entry done -> entry value; else wb0_id==q -> wb0_val; else wb1_id==q
//    -> wb1_val; else ok=0, v=0. Uses pre-edge state.
//  - Commit (one per cycle, 1-cycle latency from done visible at head): head busy && done ->
//    NORMAL/LOAD: commit_* pulse; BRANCH: commit_* pulse plus br_valid, br_pc=pc,
//    br_taken=(actual_npc != pc+4) (XLEN-wrapping add); STORE: st_commit pulse, commit_valid=0.
//    Entry busy=done=0, head wraps DEPTH->1.
//  - Mispredict: committing BRANCH with actual_npc != pred_npc -> same edge: head=tail=1, count=0, all entries
//    cleared; next cycle flush=1, flush_pc=actual_npc. Allocs/writebacks in the flush cycle are ignored.
//  - count <= count + alloc_fire - commit_fire (flush overrides to 0). rst overrides everything.
// TESTING
//  1 Reset, alloc 3 NORMAL (rd 5,6,7) -> alloc_id 1,2,3; wb1 id2 then id1 -> commits id1 then id2 in order.
//  2 Fill DEPTH=16 -> full=1 at 16, alloc_ready=0; 17th alloc ignored; commit id1 -> next alloc gets id1.
//  3 Lookup q1=4 while wb0_id=4, wb0_val=0xDEAD -> q1_ok=1, v1=0xDEAD same cycle; q1=0 -> ok=0.
//  4 BRANCH pc=0x100, pred=0x104, wb1_npc=0x200 -> br_taken=1, flush=1, flush_pc=0x200, empty=1 after.
//  5 STORE at head done -> st_commit_valid=1, st_commit_id=head, commit_valid=0; rdy=0 freezes head.
//  6 rst asserted with 5 entries in flight -> empty=1, all pulses 0, next alloc_id=1.

Source files
------------

// File: rtl/ro_buffer_param.sv
// Parametrised reorder buffer: in-order tag allocation, two writeback ports, in-order retirement
// with a store-commit pulse to the LSB and a self-clearing flush on branch mispredict.
module ro_buffer_param #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ID_W  = 5,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RID_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rdy,
    input  logic             i_alloc_valid,
    input  logic [1:0]       i_alloc_kind,
    input  logic [RID_W-1:0] i_alloc_rd,
    input  logic [XLEN-1:0]  i_alloc_pc,
    input  logic [XLEN-1:0]  i_alloc_pred_npc,
    output logic             o_alloc_ready,
    output logic [ID_W-1:0]  o_alloc_id,
    output logic             o_full,
    output logic             o_empty,
    input  logic [ID_W-1:0]  i_q1,
    input  logic [ID_W-1:0]  i_q2,
    output logic             o_q1_ok,
    output logic             o_q2_ok,
    output logic [XLEN-1:0]  o_v1,
    output logic [XLEN-1:0]  o_v2,
    input  logic [ID_W-1:0]  i_wb0_id,
    input  logic [XLEN-1:0]  i_wb0_val,
    input  logic [ID_W-1:0]  i_wb1_id,
    input  logic [XLEN-1:0]  i_wb1_val,
    input  logic [XLEN-1:0]  i_wb1_npc,
    output logic             o_commit_valid,
    output logic [ID_W-1:0]  o_commit_id,
    output logic [RID_W-1:0] o_commit_rd,
    output logic [XLEN-1:0]  o_commit_value,
    output logic             o_st_commit_valid,
    output logic [ID_W-1:0]  o_st_commit_id,
    output logic             o_br_valid,
    output logic             o_br_taken,
    output logic [XLEN-1:0]  o_br_pc,
    output logic             o_flush,
    output logic [XLEN-1:0]  o_flush_pc
);

    localparam int unsigned IDX_W       = $clog2(DEPTH);
    localparam logic [1:0]  KIND_BRANCH = 2'd1;
    localparam logic [1:0]  KIND_STORE  = 2'd2;

    // Tags run 1..DEPTH; storage is indexed by tag-1.
    function automatic logic [IDX_W-1:0] tag_idx(input logic [ID_W-1:0] tag);
        return IDX_W'(tag - ID_W'(1));
    endfunction

    function automatic logic [ID_W-1:0] next_tag(input logic [ID_W-1:0] tag);
        return (tag == ID_W'(DEPTH)) ? ID_W'(1) : tag + ID_W'(1);
    endfunction

    // Returns {ok, value}: stored result first, then same-cycle forwarding from either bus.
    function automatic logic [XLEN:0] lookup(input logic [ID_W-1:0] q, input logic done,
                                             input logic [XLEN-1:0] val,
                                             input logic [ID_W-1:0] wb0_id,
                                             input logic [XLEN-1:0] wb0_val,
                                             input logic [ID_W-1:0] wb1_id,
                                             input logic [XLEN-1:0] wb1_val);
        if (q == '0)          return '0;
        else if (done)        return {1'b1, val};
        else if (wb0_id == q) return {1'b1, wb0_val};
        else if (wb1_id == q) return {1'b1, wb1_val};
        else                  return '0;
    endfunction

    logic [ID_W-1:0]  r_head, r_tail, r_count;
    logic [DEPTH-1:0] r_busy, r_done;
    logic [1:0]       r_kind [DEPTH];
    logic [RID_W-1:0] r_rd   [DEPTH];
    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [XLEN-1:0]  r_pred [DEPTH];
    logic [XLEN-1:0]  r_val  [DEPTH];
    logic [XLEN-1:0]  r_npc  [DEPTH];

    logic             r_commit_valid, r_st_commit_valid, r_br_valid, r_br_taken, r_flush;
    logic [ID_W-1:0]  r_commit_id, r_st_commit_id;
    logic [RID_W-1:0] r_commit_rd;
    logic [XLEN-1:0]  r_commit_value, r_br_pc, r_flush_pc;

    logic [IDX_W-1:0] w_head_idx, w_tail_idx, w_wb0_idx, w_wb1_idx;
    logic             w_alloc_fire, w_commit, w_mispredict, w_wb0_hit, w_wb1_hit;
    logic [1:0]       w_head_kind;
    logic [XLEN:0]    w_lk1, w_lk2;

    always_comb begin
        w_head_idx   = tag_idx(r_head);
        w_tail_idx   = tag_idx(r_tail);
        w_wb0_idx    = tag_idx(i_wb0_id);
        w_wb1_idx    = tag_idx(i_wb1_id);
        w_alloc_fire = i_alloc_valid && o_alloc_ready;
        w_wb0_hit    = (i_wb0_id != '0) && r_busy[w_wb0_idx] && !r_flush;
        w_wb1_hit    = (i_wb1_id != '0) && r_busy[w_wb1_idx] && !r_flush;
        w_commit     = r_busy[w_head_idx] && r_done[w_head_idx];
        w_head_kind  = r_kind[w_head_idx];
        w_mispredict = w_commit && (w_head_kind == KIND_BRANCH)
                       && (r_npc[w_head_idx] != r_pred[w_head_idx]);
        w_lk1 = lookup(i_q1, r_done[tag_idx(i_q1)], r_val[tag_idx(i_q1)],
                       i_wb0_id, i_wb0_val, i_wb1_id, i_wb1_val);
        w_lk2 = lookup(i_q2, r_done[tag_idx(i_q2)], r_val[tag_idx(i_q2)],
                       i_wb0_id, i_wb0_val, i_wb1_id, i_wb1_val);
    end

    assign o_full        = (r_count == ID_W'(DEPTH));
    assign o_empty       = (r_count == '0);
    assign o_alloc_ready = !o_full && !r_flush;
    assign o_alloc_id    = r_tail;
    assign o_q1_ok       = w_lk1[XLEN];
    assign o_v1          = w_lk1[XLEN-1:0];
    assign o_q2_ok       = w_lk2[XLEN];
    assign o_v2          = w_lk2[XLEN-1:0];

    assign o_commit_valid    = r_commit_valid;
    assign o_commit_id       = r_commit_id;
    assign o_commit_rd       = r_commit_rd;
    assign o_commit_value    = r_commit_value;
    assign o_st_commit_valid = r_st_commit_valid;
    assign o_st_commit_id    = r_st_commit_id;
    assign o_br_valid        = r_br_valid;
    assign o_br_taken        = r_br_taken;
    assign o_br_pc           = r_br_pc;
    assign o_flush           = r_flush;
    assign o_flush_pc        = r_flush_pc;

    // Control state and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head            <= ID_W'(1);
            r_tail            <= ID_W'(1);
            r_count           <= '0;
            r_busy            <= '0;
            r_done            <= '0;
            r_commit_valid    <= 1'b0;
            r_commit_id       <= '0;
            r_commit_rd       <= '0;
            r_commit_value    <= '0;
            r_st_commit_valid <= 1'b0;
            r_st_commit_id    <= '0;
            r_br_valid        <= 1'b0;
            r_br_taken        <= 1'b0;
            r_br_pc           <= '0;
            r_flush           <= 1'b0;
            r_flush_pc        <= '0;
        end else if (!i_rdy) begin
            r_commit_valid    <= 1'b0;
            r_st_commit_valid <= 1'b0;
            r_br_valid        <= 1'b0;
            r_flush           <= 1'b0;
        end else begin
            r_commit_valid    <= 1'b0;
            r_st_commit_valid <= 1'b0;
            r_br_valid        <= 1'b0;
            r_flush           <= 1'b0;

            if (w_mispredict) begin
                r_head     <= ID_W'(1);
                r_tail     <= ID_W'(1);
                r_count    <= '0;
                r_busy     <= '0;
                r_done     <= '0;
                r_flush    <= 1'b1;
                r_flush_pc <= r_npc[w_head_idx];
            end else begin
                if (w_alloc_fire) begin
                    r_busy[w_tail_idx] <= 1'b1;
                    r_done[w_tail_idx] <= 1'b0;
                    r_tail             <= next_tag(r_tail);
                end
                if (w_wb0_hit) r_done[w_wb0_idx] <= 1'b1;
                if (w_wb1_hit) r_done[w_wb1_idx] <= 1'b1;
                if (w_commit) begin
                    r_busy[w_head_idx] <= 1'b0;
                    r_done[w_head_idx] <= 1'b0;
                    r_head             <= next_tag(r_head);
                end
                r_count <= r_count + ID_W'(w_alloc_fire) - ID_W'(w_commit);
            end

            if (w_commit) begin
                if (w_head_kind == KIND_STORE) begin
                    r_st_commit_valid <= 1'b1;
                    r_st_commit_id    <= r_head;
                end else begin
                    r_commit_valid <= 1'b1;
                    r_commit_id    <= r_head;
                    r_commit_rd    <= r_rd[w_head_idx];
                    r_commit_value <= r_val[w_head_idx];
                    if (w_head_kind == KIND_BRANCH) begin
                        r_br_valid <= 1'b1;
                        r_br_pc    <= r_pc[w_head_idx];
                        r_br_taken <= r_npc[w_head_idx] != (r_pc[w_head_idx] + XLEN'(4));
                    end
                end
            end
        end
    end

    // Entry payload; validity is tracked by r_busy/r_done, so no reset is needed here.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_rdy) begin
            if (w_alloc_fire) begin
                r_kind[w_tail_idx] <= i_alloc_kind;
                r_rd[w_tail_idx]   <= i_alloc_rd;
                r_pc[w_tail_idx]   <= i_alloc_pc;
                r_pred[w_tail_idx] <= i_alloc_pred_npc;
            end
            if (w_wb0_hit) r_val[w_wb0_idx] <= i_wb0_val;
            if (w_wb1_hit) begin
                r_val[w_wb1_idx] <= i_wb1_val;
                r_npc[w_wb1_idx] <= i_wb1_npc;
            end
        end
    end

endmodule

// File: tb/tb_ro_buffer_param.sv
// Scoreboard bench for ro_buffer_param: expected retirements are queued at allocation and
// checked against the commit/store/branch/flush pulses as they appear.
module tb_ro_buffer_param;

    localparam logic [1:0] K_NORMAL = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_STORE  = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [1:0]  alloc_kind = '0;
    logic [4:0]  alloc_rd = '0;
    logic [31:0] alloc_pc = '0, alloc_pred = '0;
    logic        alloc_ready, full, empty;
    logic [4:0]  alloc_id;
    logic [4:0]  q1 = '0, q2 = '0;
    logic        q1_ok, q2_ok;
    logic [31:0] v1, v2;
    logic [4:0]  wb0_id = '0, wb1_id = '0;
    logic [31:0] wb0_val = '0, wb1_val = '0, wb1_npc = '0;
    logic        commit_valid, st_commit_valid, br_valid, br_taken, flush;
    logic [4:0]  commit_id, commit_rd, st_commit_id;
    logic [31:0] commit_value, br_pc, flush_pc;

    always #5 clk = ~clk;

    ro_buffer_param dut (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
        .i_alloc_valid(alloc_valid), .i_alloc_kind(alloc_kind), .i_alloc_rd(alloc_rd),
        .i_alloc_pc(alloc_pc), .i_alloc_pred_npc(alloc_pred),
        .o_alloc_ready(alloc_ready), .o_alloc_id(alloc_id), .o_full(full), .o_empty(empty),
        .i_q1(q1), .i_q2(q2), .o_q1_ok(q1_ok), .o_q2_ok(q2_ok), .o_v1(v1), .o_v2(v2),
        .i_wb0_id(wb0_id), .i_wb0_val(wb0_val),
        .i_wb1_id(wb1_id), .i_wb1_val(wb1_val), .i_wb1_npc(wb1_npc),
        .o_commit_valid(commit_valid), .o_commit_id(commit_id), .o_commit_rd(commit_rd),
        .o_commit_value(commit_value), .o_st_commit_valid(st_commit_valid),
        .o_st_commit_id(st_commit_id), .o_br_valid(br_valid), .o_br_taken(br_taken),
        .o_br_pc(br_pc), .o_flush(flush), .o_flush_pc(flush_pc)
    );

    typedef struct {
        logic [4:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] pred;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] tb_val [32];
    logic [31:0] tb_npc [32];
    logic [4:0]  tb_tail = 5'd1;
    logic        mon_mis;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b1;
        alloc_valid = 1'b0;
        wb0_id = '0;
        wb1_id = '0;
        sb.delete();
        tb_tail = 5'd1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] pred);
        exp_t e;
        alloc_valid = 1'b1;
        alloc_kind  = kind;
        alloc_rd    = rd;
        alloc_pc    = pc;
        alloc_pred  = pred;
        #1;
        chk("alloc_ready", alloc_ready, 1);
        chk("alloc_id", alloc_id, tb_tail);
        e.id = tb_tail; e.kind = kind; e.rd = rd; e.pc = pc; e.pred = pred;
        sb.push_back(e);
        tb_tail = (tb_tail == 5'd16) ? 5'd1 : tb_tail + 5'd1;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic wb(input int bus, input logic [4:0] id, input logic [31:0] val,
                      input logic [31:0] npc);
        tb_val[id] = val;
        tb_npc[id] = npc;
        if (bus == 0) begin
            wb0_id = id; wb0_val = val;
        end else begin
            wb1_id = id; wb1_val = val; wb1_npc = npc;
        end
        tick();
        wb0_id = '0;
        wb1_id = '0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk(tag, sb.size(), 0);
        chk({tag, "_empty"}, empty, 1);
    endtask

    // Retirement monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (!rst && (commit_valid || st_commit_valid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_commit", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.kind == K_STORE) begin
                    chk("st_valid", st_commit_valid, 1);
                    chk("st_no_commit", commit_valid, 0);
                    chk("st_id", st_commit_id, mon_e.id);
                    chk("st_no_flush", flush, 0);
                end else begin
                    chk("c_valid", commit_valid, 1);
                    chk("c_no_st", st_commit_valid, 0);
                    chk("c_id", commit_id, mon_e.id);
                    chk("c_rd", commit_rd, mon_e.rd);
                    chk("c_value", commit_value, tb_val[mon_e.id]);
                    if (mon_e.kind == K_BRANCH) begin
                        mon_mis = (tb_npc[mon_e.id] != mon_e.pred);
                        chk("br_valid", br_valid, 1);
                        chk("br_pc", br_pc, mon_e.pc);
                        chk("br_taken", br_taken, tb_npc[mon_e.id] != mon_e.pc + 32'd4);
                        chk("br_flush", flush, mon_mis);
                        if (mon_mis) begin
                            chk("flush_pc", flush_pc, tb_npc[mon_e.id]);
                            sb.delete();
                            tb_tail = 5'd1;
                        end
                    end else begin
                        chk("c_no_br", br_valid, 0);
                        chk("c_no_flush", flush, 0);
                    end
                end
            end
        end else if (!rst && (br_valid || flush)) begin
            chk("stray_pulse", {br_valid, flush}, 0);
        end
    end

    initial begin
        // 1: reset state, three allocations, out-of-order writeback, in-order commit
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_id", alloc_id, 1);
        chk("rst_commit", commit_valid, 0);
        chk("rst_flush", flush, 0);
        alloc(K_NORMAL, 5'd5, 32'h10, 32'h14);
        alloc(K_NORMAL, 5'd6, 32'h14, 32'h18);
        alloc(K_NORMAL, 5'd7, 32'h18, 32'h1c);
        wb(1, 5'd2, 32'h0000_0222, 32'h0);
        tick();
        chk("t1_hold", sb.size(), 3);
        wb(1, 5'd1, 32'h0000_0111, 32'h0);
        wb(0, 5'd3, 32'h0000_0333, 32'h0);
        drain("t1_drain");

        // 2: fill to full, refused allocation, reuse of tag 1 after wrap
        do_reset();
        for (int i = 1; i <= 16; i++) alloc(K_NORMAL, 5'(i), 32'(i * 4), 32'(i * 4 + 4));
        chk("t2_full", full, 1);
        chk("t2_not_ready", alloc_ready, 0);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("t2_still_full", full, 1);
        chk("t2_tail_wrapped", alloc_id, 1);
        wb(1, 5'd1, 32'h0000_1001, 32'h0);
        tick();
        chk("t2_not_full", full, 0);
        chk("t2_reuse_id", alloc_id, 1);
        alloc(K_NORMAL, 5'd9, 32'h500, 32'h504);
        for (int i = 2; i <= 16; i++) wb(i % 2, 5'(i), 32'h1000 + 32'(i), 32'h0);
        wb(0, 5'd1, 32'h0000_2001, 32'h0);
        drain("t2_drain");

        // 3: operand lookup with same-cycle forwarding
        do_reset();
        for (int i = 1; i <= 4; i++) alloc(K_NORMAL, 5'(i + 10), 32'(i * 4), 32'(i * 4 + 4));
        q1 = 5'd4; q2 = 5'd3;
        wb0_id = 5'd4; wb0_val = 32'hDEAD; tb_val[4] = 32'hDEAD;
        wb1_id = 5'd3; wb1_val = 32'hBEEF; wb1_npc = 32'h0; tb_val[3] = 32'hBEEF;
        #1;
        chk("t3_q1_fwd_ok", q1_ok, 1);
        chk("t3_q1_fwd_v", v1, 32'hDEAD);
        chk("t3_q2_fwd_ok", q2_ok, 1);
        chk("t3_q2_fwd_v", v2, 32'hBEEF);
        q1 = 5'd0;
        #1;
        chk("t3_q0_ok", q1_ok, 0);
        chk("t3_q0_v", v1, 0);
        q1 = 5'd4;
        tick();
        wb0_id = '0;
        wb1_id = '0;
        q2 = 5'd1;
        #1;
        chk("t3_stored_ok", q1_ok, 1);
        chk("t3_stored_v", v1, 32'hDEAD);
        chk("t3_pending_ok", q2_ok, 0);
        chk("t3_pending_v", v2, 0);
        q1 = '0; q2 = '0;
        wb(0, 5'd1, 32'h31, 32'h0);
        wb(1, 5'd2, 32'h32, 32'h0);
        drain("t3_drain");

        // 4: mispredicted branch flushes; then predicted-taken and not-taken branches
        do_reset();
        alloc(K_BRANCH, 5'd0, 32'h100, 32'h104);
        alloc(K_NORMAL, 5'd3, 32'h104, 32'h108);
        wb(1, 5'd2, 32'h22, 32'h0);
        wb(1, 5'd1, 32'h55, 32'h200);
        tick();
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h200);
        chk("t4_empty", empty, 1);
        chk("t4_ready_in_flush", alloc_ready, 0);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("t4_alloc_ignored", empty, 1);
        chk("t4_head_reset", alloc_id, 1);
        chk("t4_sb_cleared", sb.size(), 0);
        alloc(K_BRANCH, 5'd0, 32'h300, 32'h308);
        alloc(K_BRANCH, 5'd0, 32'h400, 32'h404);
        wb(1, 5'd1, 32'h0, 32'h308);
        wb(1, 5'd2, 32'h0, 32'h404);
        drain("t4_drain");

        // 5: store retirement and rdy freeze
        do_reset();
        alloc(K_STORE, 5'd0, 32'h600, 32'h604);
        alloc(K_NORMAL, 5'd8, 32'h604, 32'h608);
        wb(1, 5'd2, 32'h77, 32'h0);
        wb(0, 5'd1, 32'h0, 32'h0);
        rdy = 1'b0;
        alloc_valid = 1'b1;
        repeat (3) tick();
        alloc_valid = 1'b0;
        chk("t5_frozen_sb", sb.size(), 2);
        chk("t5_frozen_id", alloc_id, 3);
        chk("t5_frozen_st", st_commit_valid, 0);
        rdy = 1'b1;
        drain("t5_drain");

        // 6: reset with entries in flight
        do_reset();
        for (int i = 1; i <= 5; i++) alloc(K_NORMAL, 5'(i), 32'(i * 4), 32'(i * 4 + 4));
        wb(0, 5'd1, 32'h61, 32'h0);
        do_reset();
        chk("t6_empty", empty, 1);
        chk("t6_commit", commit_valid, 0);
        chk("t6_st", st_commit_valid, 0);
        chk("t6_br", br_valid, 0);
        chk("t6_flush", flush, 0);
        chk("t6_id", alloc_id, 1);
        alloc(K_NORMAL, 5'd2, 32'h700, 32'h704);
        wb(1, 5'd1, 32'h62, 32'h0);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
